markup_sequencer: RTL and testbench
===================================

# markup_sequencer

Controller that sequences `element_parser` over the raw character stream. It detects `<` and enables the parser for exactly one tag. It then commits the decoded tag to a nesting stack and emits open/close events, routing all non-tag characters out as text annotated with the current depth. It sits between the character source and the layout/render stage, and is the only block that drives the parser's enable.

## Interface
- `STACK_DEPTH`, 8: maximum open-element nesting tracked; depth counter width is clog2(STACK_DEPTH)+1.
- `clock` in 1: global clock.
- `reset` in 1: synchronous, active-high.
- `char_in` in `CHAR_BITES`: upstream character.
- `char_valid` in 1: `char_in` valid this cycle.
- `char_ready` out 1: character accepted when `char_valid && char_ready`.
- `parser_char` out `CHAR_BITES`: to `element_parser.char`; equals `char_in`.
- `parser_enable` out 1: to `element_parser.state_enable`; registered.
- `parser_finished` in 1: from `has_finished`.
- `parser_tag` in `ELE_TAG_BITES`: from `element_tag`.
- `parser_closing` in 1: from `is_closing_tag`.
- `parser_has_attr` in 1, `parser_attr_type` in `ATTRIBUTE_TYPE_BITES`, `parser_attr_value` in `ATTRIBUTE_VAL_BITES`: attribute outputs of the parser.
- `attr_valid` out 1, `attr_type` out, `attr_value` out: attribute pass-through, qualified.
- `text_valid` out 1, `text_char` out `CHAR_BITES`: text character, registered.
- `evt_valid` out 1: one-cycle element event pulse, registered.
- `evt_closing` out 1, `evt_tag` out `ELE_TAG_BITES`: event kind and tag.
- `depth` out depth width: current stack depth; also qualifies text and events.
- `err_mismatch`, `err_overflow`, `err_stall` out 1 each: one-cycle error pulses.

## Operation
- States: TEXT (reset state), TAG, COMMIT.
- **TEXT:** `char_ready`=1 and `parser_enable`=0.
  - Accepted `<`: go to TAG; `parser_enable` becomes 1 on entry.
  - Accepted non-`<`: register `text_valid`=1 and `text_char`=char for one cycle. All characters pass through, whitespace included.
- **TAG:** `char_ready` = !`parser_finished`; `parser_char` = `char_in` combinationally.
  - `parser_finished`=1: latch `parser_tag` and `parser_closing`, set `parser_enable`=0, go to COMMIT.
  - `char_valid`=0 and `parser_finished`=0: pulse `err_stall`, set `parser_enable`=0, go to TEXT. The partial element is dropped with no event and no stack change. The parser has no stall input, so a tag must arrive contiguously.
  - `attr_valid` = `parser_has_attr` && state==TAG. Type and value pass through combinationally.
- **COMMIT:** `char_ready`=0. Go to TEXT, applying the following at the edge:
  - **Opening tag, `TAG_IMG` or tag 0 (unknown):** emit event, no push (void element).
  - **Opening tag, other:** if depth < `STACK_DEPTH`, push tag, depth+1, and emit event. If full, emit event, pulse `err_overflow`, and do not push.
  - **Closing tag, depth>0 and top == tag:** pop, depth−1, emit event.
  - **Closing tag, otherwise** (empty stack or mismatch): pulse `err_mismatch`, no pop, no event.
  - Emit event = `evt_valid`=1 for one cycle with `evt_closing`/`evt_tag`.
- `depth` shown with `evt_valid` is the post-update value.

## Timing
- Reset values: state TEXT, depth 0, stack cleared, `parser_enable`=0, and every registered output 0. Combinational outputs (`char_ready`, `parser_char`, attribute pass-through) follow the TEXT-state rules.
- Reset mid-tag: the parser is disabled the cycle after reset is sampled, which also resets the parser. No event or error is emitted.
- `<` accepted in cycle n: `parser_enable`=1 in n+1, and the first tag character is accepted in n+1.
- `>` accepted in cycle m:
  - `parser_finished`=1 in m+1, with `char_ready`=0.
  - COMMIT in m+2, with `parser_enable`=0.
  - `evt_valid` in m+3, with `char_ready`=1 again.
  - A `<` accepted in m+3 re-enables the parser in m+4 from a clean reset.
- Text latency: 1 cycle from acceptance to `text_valid`.
- Errors and events never coincide, except overflow, which pairs with its open event.

## Test plan
- Reset, then stream `<div>hi</div>` one character per cycle → `evt_valid` open `TAG_DIV` depth 1; text 'h','i' at depth 1; `evt_valid` close `TAG_DIV` depth 0. The two events are 3 cycles after their `>` respectively.
- `<div><img>x</div>` → img open event with depth staying 1; 'x' at depth 1; close div to depth 0; no errors.
- Nine nested `<p>` with `STACK_DEPTH`=8 → ninth open event with `err_overflow`=1 and depth 8. Then `</div>` → `err_mismatch`=1, depth stays 8, no event.
- `<a href=x>` with `parser_has_attr` stimulated → `attr_valid` only while in TAG, then open event for `TAG_A`.
- `char_valid` dropped for one cycle in the middle of `<div` → `err_stall` pulse, `parser_enable`=0 next cycle, no event, depth unchanged. A following `<p>` parses normally.
- Reset asserted during TAG → all outputs 0 after the edge, and the stack empties.

Source files
------------

// File: rtl/markup_sequencer.sv
// markup_sequencer: steers the character stream between text output and
// element_parser, and keeps the open-element nesting stack.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   char_in/valid/ready     : upstream character handshake
//   parser_char/enable      : drive element_parser (enable is registered)
//   parser_finished/tag/closing/has_attr/attr_type/attr_value : parser results
//   attr_valid/type/value   : attribute pass-through, valid only while in TAG
//   text_valid/char         : registered text character output
//   evt_valid/closing/tag   : registered one-cycle element event
//   depth                   : current nesting depth
//   err_mismatch/overflow/stall : one-cycle error pulses
module markup_sequencer #(
  parameter int STACK_DEPTH = 8,
  parameter int CHAR_BITES = 8,
  parameter int ELE_TAG_BITES = 4,
  parameter int ATTRIBUTE_TYPE_BITES = 3,
  parameter int ATTRIBUTE_VAL_BITES = 8,
  parameter int TAG_IMG = 5,
  localparam int DEPTH_BITS = $clog2(STACK_DEPTH) + 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHAR_BITES-1:0]           char_in,
  input  logic                            char_valid,
  output logic                            char_ready,
  output logic [CHAR_BITES-1:0]           parser_char,
  output logic                            parser_enable,
  input  logic                            parser_finished,
  input  logic [ELE_TAG_BITES-1:0]        parser_tag,
  input  logic                            parser_closing,
  input  logic                            parser_has_attr,
  input  logic [ATTRIBUTE_TYPE_BITES-1:0] parser_attr_type,
  input  logic [ATTRIBUTE_VAL_BITES-1:0]  parser_attr_value,
  output logic                            attr_valid,
  output logic [ATTRIBUTE_TYPE_BITES-1:0] attr_type,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  attr_value,
  output logic                            text_valid,
  output logic [CHAR_BITES-1:0]           text_char,
  output logic                            evt_valid,
  output logic                            evt_closing,
  output logic [ELE_TAG_BITES-1:0]        evt_tag,
  output logic [DEPTH_BITS-1:0]           depth,
  output logic                            err_mismatch,
  output logic                            err_overflow,
  output logic                            err_stall
);

  localparam int IDX_BITS = $clog2(STACK_DEPTH);
  localparam logic [DEPTH_BITS-1:0] FULL = DEPTH_BITS'(STACK_DEPTH);
  localparam logic [CHAR_BITES-1:0] LT = CHAR_BITES'(8'h3C);
  localparam logic [ELE_TAG_BITES-1:0] IMG = ELE_TAG_BITES'(TAG_IMG);

  typedef enum logic [1:0] {
    TEXT,
    TAG,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ELE_TAG_BITES-1:0] stack [STACK_DEPTH];
  logic [ELE_TAG_BITES-1:0] held_tag;
  logic                     held_closing;
  logic [IDX_BITS-1:0]      push_idx;
  logic [IDX_BITS-1:0]      top_idx;
  logic                     is_void;
  logic                     top_match;

  logic enable_nx;
  logic text_nx;
  logic latch;
  logic push;
  logic pop;
  logic evt_nx;
  logic mismatch_nx;
  logic overflow_nx;
  logic stall_nx;

  assign parser_char = char_in;
  assign attr_valid = parser_has_attr && (state == TAG);
  assign attr_type = parser_attr_type;
  assign attr_value = parser_attr_value;

  // Below FULL the low bits of depth address the next free slot.
  assign push_idx = depth[IDX_BITS-1:0];
  assign top_idx = push_idx - IDX_BITS'(1);
  // Tag 0 is the parser's "unknown"; it is treated like a void element.
  assign is_void = (held_tag == IMG) || (held_tag == '0);
  assign top_match = (depth != '0) && (stack[top_idx] == held_tag);

  always_comb begin
    state_nx = state;
    char_ready = 1'b0;
    enable_nx = 1'b0;
    text_nx = 1'b0;
    latch = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    evt_nx = 1'b0;
    mismatch_nx = 1'b0;
    overflow_nx = 1'b0;
    stall_nx = 1'b0;
    unique case (state)
      TEXT: begin
        char_ready = 1'b1;
        if (char_valid) begin
          if (char_in == LT) begin
            state_nx = TAG;
            enable_nx = 1'b1;
          end else begin
            text_nx = 1'b1;
          end
        end
      end
      TAG: begin
        char_ready = !parser_finished;
        if (parser_finished) begin
          state_nx = COMMIT;
          latch = 1'b1;
        end else if (!char_valid) begin
          // Parser cannot pause, so a gap kills the tag.
          state_nx = TEXT;
          stall_nx = 1'b1;
        end else begin
          enable_nx = 1'b1;
        end
      end
      COMMIT: begin
        state_nx = TEXT;
        if (!held_closing) begin
          evt_nx = 1'b1;
          if (!is_void) begin
            if (depth < FULL) begin
              push = 1'b1;
            end else begin
              overflow_nx = 1'b1;
            end
          end
        end else if (top_match) begin
          pop = 1'b1;
          evt_nx = 1'b1;
        end else begin
          mismatch_nx = 1'b1;
        end
      end
      default: state_nx = TEXT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= TEXT;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parser_enable <= 1'b0;
      text_valid <= 1'b0;
      text_char <= '0;
      evt_valid <= 1'b0;
      evt_closing <= 1'b0;
      evt_tag <= '0;
      depth <= '0;
      err_mismatch <= 1'b0;
      err_overflow <= 1'b0;
      err_stall <= 1'b0;
      held_tag <= '0;
      held_closing <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      parser_enable <= enable_nx;
      text_valid <= text_nx;
      evt_valid <= evt_nx;
      err_mismatch <= mismatch_nx;
      err_overflow <= overflow_nx;
      err_stall <= stall_nx;
      if (text_nx) begin
        text_char <= char_in;
      end
      if (latch) begin
        held_tag <= parser_tag;
        held_closing <= parser_closing;
      end
      if (evt_nx) begin
        evt_closing <= held_closing;
        evt_tag <= held_tag;
      end
      if (push) begin
        stack[push_idx] <= held_tag;
        depth <= depth + DEPTH_BITS'(1);
      end else if (pop) begin
        depth <= depth - DEPTH_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_markup_sequencer.sv
// Bench for markup_sequencer: behavioural element_parser plus a
// document-level reference model of text, events and errors.
module tb_markup_sequencer;

  localparam int SD = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] parser_char;
  logic       parser_enable;
  logic       parser_finished = 1'b0;
  logic [3:0] parser_tag = '0;
  logic       parser_closing = 1'b0;
  logic       parser_has_attr = 1'b0;
  logic [2:0] parser_attr_type = '0;
  logic [7:0] parser_attr_value = '0;
  logic       attr_valid;
  logic [2:0] attr_type;
  logic [7:0] attr_value;
  logic       text_valid;
  logic [7:0] text_char;
  logic       evt_valid;
  logic       evt_closing;
  logic [3:0] evt_tag;
  logic [3:0] depth;
  logic       err_mismatch;
  logic       err_overflow;
  logic       err_stall;

  always #5 clock = ~clock;

  markup_sequencer #(
    .STACK_DEPTH(SD),
    .CHAR_BITES(8),
    .ELE_TAG_BITES(4),
    .ATTRIBUTE_TYPE_BITES(3),
    .ATTRIBUTE_VAL_BITES(8),
    .TAG_IMG(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .parser_char(parser_char),
    .parser_enable(parser_enable),
    .parser_finished(parser_finished),
    .parser_tag(parser_tag),
    .parser_closing(parser_closing),
    .parser_has_attr(parser_has_attr),
    .parser_attr_type(parser_attr_type),
    .parser_attr_value(parser_attr_value),
    .attr_valid(attr_valid),
    .attr_type(attr_type),
    .attr_value(attr_value),
    .text_valid(text_valid),
    .text_char(text_char),
    .evt_valid(evt_valid),
    .evt_closing(evt_closing),
    .evt_tag(evt_tag),
    .depth(depth),
    .err_mismatch(err_mismatch),
    .err_overflow(err_overflow),
    .err_stall(err_stall)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [31:0] obs[$];
  logic [31:0] expq[$];
  int evt_cyc[$];
  int mstk[$];
  bit none[$];
  string pbuf = "";

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(int k, int a, int b, int d);
    return {k[7:0], a[7:0], b[7:0], d[7:0]};
  endfunction

  // {closing, tag}: div=1 p=2 a=3 img=5, anything else 0.
  function automatic logic [4:0] decode(string s);
    int i = 0;
    bit cl = 0;
    string nm = "";
    logic [3:0] t;
    if (s.len() > 0 && s[0] == 8'h2F) begin
      cl = 1;
      i = 1;
    end
    while (i < s.len() && s[i] != 8'h20 && s[i] != 8'h3E) begin
      nm = {nm, s.substr(i, i)};
      i++;
    end
    case (nm)
      "div": t = 4'd1;
      "p": t = 4'd2;
      "a": t = 4'd3;
      "img": t = 4'd5;
      default: t = 4'd0;
    endcase
    return {cl, t};
  endfunction

  always @(posedge clock) begin
    if (reset || !parser_enable) begin
      pbuf = "";
      parser_finished <= 1'b0;
      parser_has_attr <= 1'b0;
    end else if (!parser_finished && char_valid && char_ready) begin
      pbuf = $sformatf("%s%c", pbuf, char_in);
      if (char_in == 8'h3D) parser_has_attr <= 1'b1;
      if (char_in == 8'h3E) begin
        {parser_closing, parser_tag} <= decode(pbuf);
        parser_finished <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (text_valid) obs.push_back(enc(1, text_char, 0, depth));
      if (evt_valid) begin
        obs.push_back(enc(2, evt_closing, evt_tag, depth));
        evt_cyc.push_back(cyc);
      end
      if (err_mismatch) obs.push_back(enc(3, 0, 0, depth));
      if (err_overflow) obs.push_back(enc(4, 0, 0, depth));
      if (err_stall) obs.push_back(enc(5, 0, 0, depth));
    end
  end

  function automatic void commit(string b);
    logic [4:0] d = decode(b);
    int tg = int'(d[3:0]);
    if (!d[4]) begin
      if (tg == 5 || tg == 0) begin
        expq.push_back(enc(2, 0, tg, mstk.size()));
      end else if (mstk.size() < SD) begin
        mstk.push_back(tg);
        expq.push_back(enc(2, 0, tg, mstk.size()));
      end else begin
        expq.push_back(enc(2, 0, tg, mstk.size()));
        expq.push_back(enc(4, 0, 0, mstk.size()));
      end
    end else if (mstk.size() > 0 && mstk[$] == tg) begin
      void'(mstk.pop_back());
      expq.push_back(enc(2, 1, tg, mstk.size()));
    end else begin
      expq.push_back(enc(3, 0, 0, mstk.size()));
    end
  endfunction

  function automatic void model(string s, bit g[$]);
    bit intag = 0;
    string b = "";
    for (int i = 0; i < s.len(); i++) begin
      byte c = s[i];
      if (intag && i < g.size() && g[i]) begin
        expq.push_back(enc(5, 0, 0, mstk.size()));
        intag = 0;
      end
      if (!intag) begin
        if (c == 8'h3C) begin
          intag = 1;
          b = "";
        end else begin
          expq.push_back(enc(1, int'(c), 0, mstk.size()));
        end
      end else begin
        b = $sformatf("%s%c", b, c);
        if (c == 8'h3E) begin
          commit(b);
          intag = 0;
        end
      end
    end
  endfunction

  task automatic put(byte c);
    int n = 0;
    char_in = c;
    char_valid = 1'b1;
    #1;
    while (!char_ready && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 20) chk("ready_timeout", char_ready, 1);
    last_acc = cyc;
    @(negedge clock);
  endtask

  task automatic idle(int n);
    char_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic run(string s, bit g[$]);
    for (int i = 0; i < s.len(); i++) begin
      if (i < g.size() && g[i]) idle(1);
      put(s[i]);
    end
  endtask

  task automatic compare(string tag);
    int n;
    idle(6);
    chk({tag, "_count"}, obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_item%0d", tag, i), obs[i], expq[i]);
    end
    obs.delete();
    expq.delete();
    evt_cyc.delete();
  endtask

  task automatic do_doc(string tag, string s, bit g[$]);
    model(s, g);
    run(s, g);
    compare(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    char_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mstk.delete();
    obs.delete();
    expq.delete();
    evt_cyc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int m;
    int m2;
    string toks[13];
    string doc;
    bit g[$];
    toks = '{"<div>", "<p>", "<a href=y>", "<img>", "<b>", "</div>",
             "</p>", "</a>", "</b>", "h", "i", " ", "x"};

    repeat (3) @(negedge clock);
    chk("rst_enable", parser_enable, 0);
    chk("rst_outs", {text_valid, evt_valid, err_mismatch, err_overflow, err_stall}, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ready", char_ready, 1);
    reset = 1'b0;

    // <div>hi</div> with latency checks around the first tag
    model("<div>hi</div>", none);
    put("<");
    chk("en_after_lt", parser_enable, 1);
    chk("ready_in_tag", char_ready, 1);
    put("d");
    chk("pchar", parser_char, 8'h64);
    put("i");
    put("v");
    put(">");
    m = last_acc;
    chk("m1_ready", char_ready, 0);
    chk("m1_enable", parser_enable, 1);
    idle(1);
    chk("m2_enable", parser_enable, 0);
    chk("m2_ready", char_ready, 0);
    idle(1);
    chk("m3_evt", evt_valid, 1);
    chk("m3_ready", char_ready, 1);
    chk("m3_cycle", cyc - m, 3);
    run("hi</div>", none);
    m2 = last_acc;
    idle(4);
    chk("close_evts", evt_cyc.size(), 2);
    if (evt_cyc.size() == 2) chk("close_lat", evt_cyc[1] - m2, 3);
    compare("divhi");

    do_doc("img", "<div><img>x</div>", none);

    do_reset();
    for (int i = 0; i < 9; i++) do_doc($sformatf("p%0d", i), "<p>", none);
    chk("full_depth", depth, SD);
    do_doc("mis", "</div>", none);
    chk("mis_depth", depth, SD);

    do_reset();
    parser_attr_type = 3'($urandom_range(1, 7));
    parser_attr_value = 8'($urandom_range(1, 255));
    model("<a href=x>", none);
    chk("attr_text", attr_valid, 0);
    run("<a href=x", none);
    put(">");
    chk("attr_tag", attr_valid, 1);
    chk("attr_type", attr_type, parser_attr_type);
    chk("attr_val", attr_value, parser_attr_value);
    idle(1);
    chk("attr_commit", attr_valid, 0);
    compare("attr");

    // gap inside "<di", then a clean <p>
    g = '{0, 0, 0, 1, 0, 0};
    model("<di<p>", g);
    put("<");
    put("d");
    put("i");
    idle(1);
    chk("stall_pulse", err_stall, 1);
    chk("stall_en", parser_enable, 0);
    chk("stall_evt", evt_valid, 0);
    run("<p>", none);
    compare("stall");

    for (int d = 0; d < 40; d++) begin
      doc = "";
      g.delete();
      for (int t = 0; t < 8; t++) doc = {doc, toks[$urandom_range(0, 12)]};
      for (int i = 0; i < doc.len(); i++) g.push_back($urandom_range(0, 9) == 0);
      do_doc($sformatf("rnd%0d", d), doc, g);
    end

    // reset in the middle of a tag empties the stack
    do_doc("pre", "<div><p>", none);
    put("<");
    put("d");
    reset = 1'b1;
    char_valid = 1'b0;
    @(negedge clock);
    chk("mid_enable", parser_enable, 0);
    chk("mid_depth", depth, 0);
    chk("mid_outs", {text_valid, evt_valid, err_mismatch, err_overflow, err_stall}, 0);
    chk("mid_ready", char_ready, 1);
    reset = 1'b0;
    mstk.delete();
    obs.delete();
    expq.delete();
    evt_cyc.delete();
    do_doc("post", "</div><p>", none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
